// File: rtl/exhaustive_stim_checker_pkg.sv
// Shared FSM encoding and width helper for the exhaustive stimulus checker
// and its hold timer.
package exhaustive_stim_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bits needed to count 0..value-1, never less than one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/exhaustive_stim_checker_hold_timer.sv
// Counts the clocks a stimulus vector has been held and flags the last one,
// which is the clock on which the DUT output is compared.
module exhaustive_stim_checker_hold_timer
  import exhaustive_stim_checker_pkg::*;
#(
  parameter int HOLD_CYCLES = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_last_tick
);

  localparam int CNT_W = clog2_min1(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_last;

  assign w_at_last   = (r_cnt == LAST_CNT);
  assign o_last_tick = i_en && w_at_last;

  // Wraps to zero on the compare clock so the next vector starts a fresh hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || (i_en && w_at_last)) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/exhaustive_stim_checker.sv
// Sweeps every N_IN-bit input vector into a small DUT, holds each for
// HOLD_CYCLES clocks and scores the DUT output against a reference output.
module exhaustive_stim_checker
  import exhaustive_stim_checker_pkg::*;
#(
  parameter int N_IN        = 2,
  parameter int N_OUT       = 1,
  parameter int HOLD_CYCLES = 10,
  parameter int ERR_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              loop_mode,
  input  logic              abort,
  output logic [N_IN-1:0]   stim,
  input  logic [N_OUT-1:0]  dut_y,
  input  logic [N_OUT-1:0]  exp_y,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [N_IN-1:0]   first_err_vec,
  output logic              first_err_valid
);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

  state_t           r_state;
  logic             r_loop;
  logic [N_IN-1:0]  r_stim;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err;
  logic [N_IN-1:0]  r_first_vec;
  logic             r_first_valid;

  logic w_drive;
  logic w_cmp;
  logic w_mismatch;
  logic w_last_vec;

  assign w_drive    = (r_state == ST_DRIVE);
  assign w_mismatch = w_cmp && (dut_y != exp_y);
  assign w_last_vec = &r_stim;

  exhaustive_stim_checker_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (!w_drive),
    .i_en        (w_drive),
    .o_last_tick (w_cmp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_loop        <= 1'b0;
      r_stim        <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_err         <= '0;
      r_first_vec   <= '0;
      r_first_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          // Abort is meaningless here, so start alone decides.
          if (start) begin
            r_state       <= ST_DRIVE;
            r_loop        <= loop_mode;
            r_stim        <= '0;
            r_busy        <= 1'b1;
            r_pass        <= 1'b0;
            r_err         <= '0;
            r_first_vec   <= '0;
            r_first_valid <= 1'b0;
          end
        end

        ST_DRIVE: begin
          if (w_mismatch) begin
            r_err <= sat_inc(r_err);
            if (!r_first_valid) begin
              r_first_vec   <= r_stim;
              r_first_valid <= 1'b1;
            end
          end
          // Abort freezes stim on the vector being driven; a compare due now still scored above.
          if (abort) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
          end else if (w_cmp) begin
            if (!w_last_vec) begin
              r_stim <= r_stim + 1'b1;
            end else if (r_loop) begin
              r_stim <= '0;
            end else begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
            end
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b1;
          r_pass  <= (r_err == '0);
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign stim            = r_stim;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign err_count       = r_err;
  assign first_err_vec   = r_first_vec;
  assign first_err_valid = r_first_valid;

endmodule

// File: tb/tb_exhaustive_stim_checker.sv
// Bench for exhaustive_stim_checker: two instances (slow 2-bit sweep, fast 4-bit
// sweep with a 2-bit counter) scored every cycle against a cycle-count model.
module tb_exhaustive_stim_checker;

  typedef struct {
    bit running;
    bit done_pend;
    bit busy;
    bit done;
    bit pass;
    bit fvalid;
    bit loop;
    int k;
    int stim;
    int err;
    int fev;
  } model_t;

  logic clk;
  logic rst_n;
  logic chk_en;
  int   n_chk;
  int   n_pass;

  logic       startA, loopA, abortA;
  logic [1:0] stimA, fevA;
  logic [0:0] dutyA, expyA;
  logic       busyA, doneA, passA, fvA;
  logic [7:0] errA;
  int         modeA, faultA;

  logic       startB, loopB, abortB;
  logic [3:0] stimB, fevB;
  logic [0:0] dutyB, expyB;
  logic       busyB, doneB, passB, fvB;
  logic [1:0] errB;
  int         modeB, faultB;

  model_t mA, mB;

  // Reference is the AND of all stimulus bits; the "DUT" may deviate by mode.
  function automatic bit exp_fn(input int s, input int nin);
    return s == ((1 << nin) - 1);
  endfunction

  function automatic bit dut_fn(input int s, input int mode, input int fault, input int nin);
    bit y;
    case (mode)
      0:       y = exp_fn(s, nin);
      1:       y = (s != 0);
      2:       y = !exp_fn(s, nin);
      default: y = exp_fn(s, nin) ^ fault[s];
    endcase
    return y;
  endfunction

  function automatic model_t model_zero();
    model_t z;
    z = '{default: 0};
    return z;
  endfunction

  // k counts clocks since the start edge: vector index is k/hold, compare when k%hold==0.
  function automatic model_t step(input model_t m, input int nin, input int hold, input int errw,
                                  input bit st, input bit ab, input bit lp, input int mode, input int fault);
    model_t r;
    int nvec, errmax;
    bit fin;
    r = m;
    nvec = 1 << nin;
    errmax = (1 << errw) - 1;
    fin = 0;
    r.done = 0;
    if (m.done_pend) begin
      r.done = 1;
      r.pass = (m.err == 0);
      r.done_pend = 0;
    end else if (!m.running) begin
      if (st) begin
        r.running = 1; r.busy = 1; r.k = 0; r.stim = 0; r.err = 0;
        r.fev = 0; r.fvalid = 0; r.pass = 0; r.loop = lp;
      end
    end else begin
      r.k = m.k + 1;
      if (r.k % hold == 0) begin
        if (dut_fn(m.stim, mode, fault, nin) != exp_fn(m.stim, nin)) begin
          if (m.err < errmax) r.err = m.err + 1;
          if (!m.fvalid) begin
            r.fev = m.stim;
            r.fvalid = 1;
          end
        end
        if (!m.loop && r.k == nvec * hold) fin = 1;
      end
      if (ab || fin) begin
        r.running = 0; r.busy = 0; r.done_pend = 1;
      end else begin
        r.stim = (r.k / hold) % nvec;
      end
    end
    return r;
  endfunction

  assign expyA = exp_fn(int'(stimA), 2);
  assign dutyA = dut_fn(int'(stimA), modeA, faultA, 2);
  assign expyB = exp_fn(int'(stimB), 4);
  assign dutyB = dut_fn(int'(stimB), modeB, faultB, 4);

  exhaustive_stim_checker #(.N_IN(2), .N_OUT(1), .HOLD_CYCLES(10), .ERR_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(startA), .loop_mode(loopA), .abort(abortA),
    .stim(stimA), .dut_y(dutyA), .exp_y(expyA), .busy(busyA), .done(doneA), .pass(passA),
    .err_count(errA), .first_err_vec(fevA), .first_err_valid(fvA)
  );

  exhaustive_stim_checker #(.N_IN(4), .N_OUT(1), .HOLD_CYCLES(1), .ERR_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(startB), .loop_mode(loopB), .abort(abortB),
    .stim(stimB), .dut_y(dutyB), .exp_y(expyB), .busy(busyB), .done(doneB), .pass(passB),
    .err_count(errB), .first_err_vec(fevB), .first_err_valid(fvB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mA <= model_zero();
    else        mA <= step(mA, 2, 10, 8, startA, abortA, loopA, modeA, faultA);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mB <= model_zero();
    else        mB <= step(mB, 4, 1, 2, startB, abortB, loopB, modeB, faultB);
  end

  task automatic cmp(input string nm, input int st, input bit bz, input bit dn, input bit ps,
                     input int er, input int fv, input bit fvv, input model_t m);
    n_chk++;
    if (st == m.stim && bz == m.busy && dn == m.done && ps == m.pass &&
        er == m.err && fv == m.fev && fvv == m.fvalid) begin
      n_pass++;
    end else begin
      $display("FAIL %s t=%0t dut stim=%0d busy=%0b done=%0b pass=%0b err=%0d fev=%0d fvalid=%0b | expected stim=%0d busy=%0b done=%0b pass=%0b err=%0d fev=%0d fvalid=%0b",
               nm, $time, st, bz, dn, ps, er, fv, fvv,
               m.stim, m.busy, m.done, m.pass, m.err, m.fev, m.fvalid);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("cycle_A", int'(stimA), busyA, doneA, passA, int'(errA), int'(fevA), fvA, mA);
      cmp("cycle_B", int'(stimB), busyB, doneB, passB, int'(errB), int'(fevB), fvB, mB);
    end
  end

  task automatic lit(input string nm, input int act, input int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d", nm, act, expv);
  endtask

  task automatic set_start(input int i, input logic v);
    if (i == 0) startA = v; else startB = v;
  endtask
  task automatic set_abort(input int i, input logic v);
    if (i == 0) abortA = v; else abortB = v;
  endtask
  task automatic set_loop(input int i, input logic v);
    if (i == 0) loopA = v; else loopB = v;
  endtask
  function automatic bit get_done(input int i);
    return (i == 0) ? doneA : doneB;
  endfunction

  // Start a sweep, optionally abort / re-start at given clock counts, wait for done.
  task automatic run(input int i, input bit lp, input int abort_at, input bit abort_with_start,
                     input int restart_at, input int budget, output int cyc);
    bit seen;
    seen = 0;
    cyc = 0;
    @(negedge clk);
    set_start(i, 1'b1); set_loop(i, lp); set_abort(i, abort_with_start);
    @(negedge clk);
    set_start(i, 1'b0); set_abort(i, 1'b0); set_loop(i, !lp);
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      set_abort(i, n == abort_at);
      set_start(i, n == restart_at);
      if (get_done(i)) begin
        cyc = n;
        seen = 1;
        break;
      end
    end
    set_abort(i, 1'b0);
    set_start(i, 1'b0);
    if (!seen) begin
      n_chk++;
      $display("FAIL done_timeout inst=%0d got=no_done expected=done within %0d clocks", i, budget);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    n_chk = 0; n_pass = 0; chk_en = 0;
    startA = 0; loopA = 0; abortA = 0; modeA = 0; faultA = 0;
    startB = 0; loopB = 0; abortB = 0; modeB = 0; faultB = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_en = 1;
    repeat (3) @(negedge clk);
    lit("rst_stimA", int'(stimA), 0);
    lit("rst_busyA", int'(busyA), 0);
    lit("rst_doneA", int'(doneA), 0);
    lit("rst_errB", int'(errB), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Matching DUT: clean single sweep, then abort in idle does nothing.
    modeA = 0;
    run(0, 0, 0, 0, 0, 100, cyc);
    lit("t1_done_clk", cyc, 41);
    lit("t1_pass", int'(passA), 1);
    lit("t1_err", int'(errA), 0);
    lit("t1_fvalid", int'(fvA), 0);
    lit("t1_model_pass", int'(mA.pass), 1);
    abortA = 1; @(negedge clk); abortA = 0; @(negedge clk);
    lit("t1_idle_abort_busy", int'(busyA), 0);
    lit("t1_idle_abort_done", int'(doneA), 0);

    // OR against AND mismatches on vectors 1 and 2.
    modeA = 1;
    run(0, 0, 0, 0, 0, 100, cyc);
    lit("t2_err", int'(errA), 2);
    lit("t2_fev", int'(fevA), 1);
    lit("t2_pass", int'(passA), 0);
    lit("t2_model_err", mA.err, 2);

    // Looping for three full sweeps then abort.
    run(0, 1, 125, 0, 0, 200, cyc);
    lit("t3_err", int'(errA), 6);
    lit("t3_busy", int'(busyA), 0);
    lit("t3_done_clk", cyc, 127);
    lit("t3_model_err", mA.err, 6);

    // Small counter saturates.
    modeB = 2;
    run(1, 1, 40, 0, 0, 100, cyc);
    lit("t4_err_sat", int'(errB), 3);
    lit("t4_pass", int'(passB), 0);

    // Reset mid-sweep, then a clean sweep.
    @(negedge clk); modeA = 1; loopA = 0; startA = 1;
    @(negedge clk); startA = 0;
    repeat (24) @(negedge clk);
    lit("t5_pre_err", int'(errA), 1);
    @(posedge clk); #2 rst_n = 1'b0;
    @(negedge clk);
    lit("t5_rst_busy", int'(busyA), 0);
    lit("t5_rst_err", int'(errA), 0);
    lit("t5_rst_stim", int'(stimA), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (45) @(negedge clk);
    lit("t5_no_done", int'(doneA), 0);
    modeA = 0;
    run(0, 0, 0, 0, 0, 100, cyc);
    lit("t5_clean_clk", cyc, 41);
    lit("t5_clean_pass", int'(passA), 1);

    // One-clock hold, 16 vectors; a start while busy is ignored.
    modeB = 0;
    run(1, 0, 0, 0, 5, 60, cyc);
    lit("t6_done_clk", cyc, 17);
    lit("t6_pass", int'(passB), 1);
    lit("t6_model_pass", int'(mB.pass), 1);

    // Randomised sweeps: random fault tables, loop mode, abort timing.
    for (int it = 0; it < 16; it++) begin
      int inst, lim, ab;
      bit lp, abs;
      inst = it % 2;
      lp = 1'($urandom_range(0, 1));
      abs = ($urandom_range(0, 5) == 0);
      lim = (inst == 0) ? 40 : 16;
      if (inst == 0) begin
        modeA = int'($urandom_range(0, 3)); faultA = int'($urandom);
      end else begin
        modeB = int'($urandom_range(0, 3)); faultB = int'($urandom);
      end
      if (lp) ab = int'($urandom_range(1, 3 * lim));
      else    ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, lim + 5)) : 0;
      run(inst, lp, ab, abs, int'($urandom_range(0, lim)), 3 * lim + 20, cyc);
      repeat (int'($urandom_range(1, 4))) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
